issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- In-order dual-entry instruction queue between the decode stage and the issue unit that steers instructions to the Branch and Memory pipelines.
- Accepts up to two decoded instructions per cycle from decode, buffers them, and presents the oldest one or two to the issue unit.
- Each cycle it decides whether the head pair may dual-issue. It blocks pairing on a RAW dependency or a pipeline-resource conflict (two memory ops, or two branch/jump ops).

Parameters:
DEPTH, 8, number of queue entries; power of two, at least 4.
PAYLOAD_W, 64, opaque decoded control bundle per entry (ALU op, imm, load/store type, shift size, etc.), passed through unmodified.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all entries (branch mispredict/redirect)
in_valid  in  2  push request; bit0 older; 2'b10 is illegal and ignored entirely
in_pc  in  2x32  PC per slot
in_rs1, in_rs2, in_rd  in  2x5 each  register indices per slot
in_uses_rs1, in_uses_rs2, in_writes_rd  in  2 each  operand-use and write flags per slot
in_is_mem  in  2  load or store per slot
in_is_br  in  2  branch, JAL or JALR per slot
in_payload  in  2xPAYLOAD_W  opaque bundle per slot
in_ready  out  1  queue can take two entries this cycle
out_valid  out  2  bit0: head entry valid; bit1: head+1 may issue with it
out_pc, out_rs1, out_rs2, out_rd, out_uses_rs1, out_uses_rs2, out_writes_rd, out_is_mem, out_is_br, out_payload  out  2x(same widths)  head (slot0) and head+1 (slot1) fields
issue_stall  in  1  issue unit cannot accept; pop nothing
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Reset is asynchronous, active-low, single clock clk.
  - On reset: rd/wr pointers=0, count=0, empty=1, in_ready=1, out_valid=0.
  - Storage contents are don't-care.
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH; count is tracked explicitly.
- in_ready = (count <= DEPTH-2), computed from registered count only, with no dependence on same-cycle pop.
- Push occurs when in_ready & in_valid∈{01,11}.
  - 01: write slot0 at wr_ptr; count +1.
  - 11: write slot0 at wr_ptr and slot1 at wr_ptr+1; count +2.
  - Pushes with in_ready=0 are dropped; decode must hold its data.
- Output fields are read combinationally from entries rd_ptr and rd_ptr+1. A pushed entry is visible on the outputs the cycle after the push (latency 1, no bypass).
- out_valid[0] = (count>=1).
- out_valid[1] = (count>=2) & ~pair_block, where pair_block is the OR of:
  - RAW: e0.writes_rd & e0.rd!=0 & ((e1.uses_rs1 & e1.rs1==e0.rd) | (e1.uses_rs2 & e1.rs2==e0.rd)).
  - WAW: e0.writes_rd & e1.writes_rd & e0.rd==e1.rd & e0.rd!=0.
  - e0.is_mem & e1.is_mem.
  - e0.is_br & e1.is_br.
  - e0.is_br, so nothing issues in the same cycle as an older control transfer.
- Pop: when ~issue_stall, remove popcount(out_valid) entries, advancing rd_ptr by 0/1/2.
- Count update: count_next = count + push_n - pop_n. Simultaneous push and pop is allowed.
- flush has priority over push and pop. Next cycle: pointers=0, count=0, out_valid=0. That same cycle's push is discarded.
- Wrap: entry DEPTH-1 pairs with entry 0 as head+1.
- Overflow is impossible by construction.
- Underflow is impossible by construction, since out_valid gates pop.

Test Plan:
- Reset/empty: assert rst_n=0 mid-run with count=5 -> immediately count=0, empty=1, out_valid=00, in_ready=1; after release, push pair PC 0x100/0x104 -> next cycle out_valid=11, out_pc={0x100,0x104}.
- RAW block: e0 writes x5, e1 uses rs1=x5 -> out_valid=01; pop 1; next cycle e1 is head with out_valid[0]=1. Repeat with rd=x0 -> out_valid=11.
- Resource block: two loads at head -> 01; load+branch -> 11; branch+ALU -> 01; two ALU ops with independent regs -> 11.
- Full/backpressure: DEPTH=8, push 4 pairs with issue_stall=1 -> count=8, in_ready=0; further push is dropped with count unchanged. Release stall -> pops 2/cycle; in_ready returns to 1 when count=6.
- Wrap plus simultaneous ops: hold count=7 with rd_ptr=7; pairs of head entries 7 and 0 issue correctly; push 2 and pop 2 in the same cycle -> count constant, order preserved over 20 random cycles against a reference model.
- Flush: count=6, flush=1 with in_valid=11 in the same cycle -> next cycle count=0, out_valid=00; the following push appears at the head with correct PC.

Source files
------------

// File: rtl/issue_queue.sv
// In-order dual-entry issue queue: buffers up to two decoded instructions per
// cycle and presents the oldest pair, blocking dual issue on hazards.
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [1:0]                    in_valid,
    input  logic [1:0][31:0]              in_pc,
    input  logic [1:0][4:0]               in_rs1,
    input  logic [1:0][4:0]               in_rs2,
    input  logic [1:0][4:0]               in_rd,
    input  logic [1:0]                    in_uses_rs1,
    input  logic [1:0]                    in_uses_rs2,
    input  logic [1:0]                    in_writes_rd,
    input  logic [1:0]                    in_is_mem,
    input  logic [1:0]                    in_is_br,
    input  logic [1:0][PAYLOAD_W-1:0]     in_payload,
    output logic                          in_ready,
    output logic [1:0]                    out_valid,
    output logic [1:0][31:0]              out_pc,
    output logic [1:0][4:0]               out_rs1,
    output logic [1:0][4:0]               out_rs2,
    output logic [1:0][4:0]               out_rd,
    output logic [1:0]                    out_uses_rs1,
    output logic [1:0]                    out_uses_rs2,
    output logic [1:0]                    out_writes_rd,
    output logic [1:0]                    out_is_mem,
    output logic [1:0]                    out_is_br,
    output logic [1:0][PAYLOAD_W-1:0]     out_payload,
    input  logic                          issue_stall,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]          pc;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 uses_rs1;
        logic                 uses_rs2;
        logic                 writes_rd;
        logic                 is_mem;
        logic                 is_br;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t [1:0]    wr_ent;
    entry_t [1:0]    rd_ent;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            push_en, push2;
    logic [CW-1:0]   push_n, pop_n;
    logic            raw, waw, pair_block;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        assign wr_ent[s] = '{pc: in_pc[s], rs1: in_rs1[s], rs2: in_rs2[s], rd: in_rd[s],
                             uses_rs1: in_uses_rs1[s], uses_rs2: in_uses_rs2[s],
                             writes_rd: in_writes_rd[s], is_mem: in_is_mem[s],
                             is_br: in_is_br[s], payload: in_payload[s]};
        assign out_pc[s]        = rd_ent[s].pc;
        assign out_rs1[s]       = rd_ent[s].rs1;
        assign out_rs2[s]       = rd_ent[s].rs2;
        assign out_rd[s]        = rd_ent[s].rd;
        assign out_uses_rs1[s]  = rd_ent[s].uses_rs1;
        assign out_uses_rs2[s]  = rd_ent[s].uses_rs2;
        assign out_writes_rd[s] = rd_ent[s].writes_rd;
        assign out_is_mem[s]    = rd_ent[s].is_mem;
        assign out_is_br[s]     = rd_ent[s].is_br;
        assign out_payload[s]   = rd_ent[s].payload;
    end

    // Pointer arithmetic wraps naturally, so entry DEPTH-1 pairs with entry 0.
    assign rd_ent[0] = mem[rd_ptr];
    assign rd_ent[1] = mem[rd_ptr + AW'(1)];

    assign raw = rd_ent[0].writes_rd & (rd_ent[0].rd != 5'd0) &
                 ((rd_ent[1].uses_rs1 & (rd_ent[1].rs1 == rd_ent[0].rd)) |
                  (rd_ent[1].uses_rs2 & (rd_ent[1].rs2 == rd_ent[0].rd)));
    assign waw = rd_ent[0].writes_rd & rd_ent[1].writes_rd &
                 (rd_ent[0].rd == rd_ent[1].rd) & (rd_ent[0].rd != 5'd0);
    // An older control transfer never has anything issue alongside it.
    assign pair_block = raw | waw | (rd_ent[0].is_mem & rd_ent[1].is_mem) | rd_ent[0].is_br;

    assign out_valid[0] = (count != '0);
    assign out_valid[1] = (count >= CW'(2)) & ~pair_block;
    assign in_ready     = (count <= CW'(DEPTH - 2));
    assign empty        = (count == '0);

    assign push_en = in_ready & in_valid[0];
    assign push2   = push_en & in_valid[1];
    assign push_n  = CW'(push_en) + CW'(push2);
    assign pop_n   = issue_stall ? '0 : CW'(out_valid[0]) + CW'(out_valid[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + push_n - pop_n;
        end
    end

    // Storage is not reset; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem[wr_ptr] <= wr_ent[0];
            if (push2) mem[wr_ptr + AW'(1)] <= wr_ent[1];
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: directed hazard/full/wrap/flush scenarios
// followed by random traffic, all checked against a queue-based model.
module tb_issue_queue;
    localparam int DEPTH = 8;
    localparam int PW    = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, wr, mem, br;
        logic [63:0] pl;
    } inst_t;

    logic clk = 0, rst_n = 0, flush = 0, issue_stall = 0;
    logic [1:0] in_valid = '0;
    logic [1:0][31:0] in_pc = '0;
    logic [1:0][4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [1:0] in_uses_rs1 = '0, in_uses_rs2 = '0, in_writes_rd = '0, in_is_mem = '0, in_is_br = '0;
    logic [1:0][PW-1:0] in_payload = '0;
    logic in_ready, empty;
    logic [1:0] out_valid;
    logic [1:0][31:0] out_pc;
    logic [1:0][4:0] out_rs1, out_rs2, out_rd;
    logic [1:0] out_uses_rs1, out_uses_rs2, out_writes_rd, out_is_mem, out_is_br;
    logic [1:0][PW-1:0] out_payload;
    logic [CW-1:0] count;

    int checks = 0, errors = 0;
    inst_t sb[$];

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
        .in_is_mem(in_is_mem), .in_is_br(in_is_br), .in_payload(in_payload),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2), .out_writes_rd(out_writes_rd),
        .out_is_mem(out_is_mem), .out_is_br(out_is_br), .out_payload(out_payload),
        .issue_stall(issue_stall), .count(count), .empty(empty)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic inst_t mk(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic wr, logic u1, logic u2, logic mem, logic br);
        return '{pc: pc, rs1: rs1, rs2: rs2, rd: rd, u1: u1, u2: u2, wr: wr,
                 mem: mem, br: br, pl: {pc, ~pc}};
    endfunction

    function automatic inst_t alu(logic [31:0] pc, logic [4:0] rd);
        return mk(pc, rd, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic inst_t rnd(logic [31:0] pc);
        return mk(pc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    endfunction

    // Reference pairing rule: the younger op may go along unless it depends on,
    // overwrites, or competes for a pipe with the older one, or the older is a branch.
    function automatic bit can_pair(inst_t a, inst_t b);
        if (a.br) return 0;
        if (a.mem && b.mem) return 0;
        if (a.wr && a.rd != 0) begin
            if (b.u1 && b.rs1 == a.rd) return 0;
            if (b.u2 && b.rs2 == a.rd) return 0;
            if (b.wr && b.rd == a.rd) return 0;
        end
        return 1;
    endfunction

    function automatic inst_t in_slot(int s);
        return '{pc: in_pc[s], rs1: in_rs1[s], rs2: in_rs2[s], rd: in_rd[s], u1: in_uses_rs1[s],
                 u2: in_uses_rs2[s], wr: in_writes_rd[s], mem: in_is_mem[s], br: in_is_br[s],
                 pl: in_payload[s]};
    endfunction

    function automatic inst_t out_slot(int s);
        return '{pc: out_pc[s], rs1: out_rs1[s], rs2: out_rs2[s], rd: out_rd[s], u1: out_uses_rs1[s],
                 u2: out_uses_rs2[s], wr: out_writes_rd[s], mem: out_is_mem[s], br: out_is_br[s],
                 pl: out_payload[s]};
    endfunction

    task automatic drive(input logic [1:0] v, input inst_t a, input inst_t b, input logic st, input logic fl);
        inst_t s [2];
        s[0] = a; s[1] = b;
        in_valid = v; issue_stall = st; flush = fl;
        for (int i = 0; i < 2; i++) begin
            in_pc[i] = s[i].pc; in_rs1[i] = s[i].rs1; in_rs2[i] = s[i].rs2; in_rd[i] = s[i].rd;
            in_uses_rs1[i] = s[i].u1; in_uses_rs2[i] = s[i].u2; in_writes_rd[i] = s[i].wr;
            in_is_mem[i] = s[i].mem; in_is_br[i] = s[i].br; in_payload[i] = s[i].pl;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic st);
        drive(2'b00, '0, '0, st, 1'b0);
    endtask

    task automatic do_flush();
        drive(2'b00, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic pair_test(input string name, input inst_t a, input inst_t b, input logic [1:0] exp);
        drive(2'b11, a, b, 1'b1, 1'b0);
        chk(name, 128'(out_valid), 128'(exp));
        do_flush();
    endtask

    // Monitor: compares outputs against the model, then advances the model
    // using the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        int n;
        bit v0, v1;
        if (!rst_n) begin
            sb.delete();
            chk("rst_count", 128'(count), 128'(0));
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_empty", 128'(empty), 128'(1));
            chk("rst_in_ready", 128'(in_ready), 128'(1));
        end else begin
            n  = sb.size();
            v0 = (n >= 1);
            v1 = (n >= 2) && can_pair(sb[0], sb[1]);
            chk("count", 128'(count), 128'(n));
            chk("empty", 128'(empty), 128'(n == 0));
            chk("in_ready", 128'(in_ready), 128'(n <= DEPTH - 2));
            chk("out_valid", 128'(out_valid), 128'({v1, v0}));
            if (n >= 1) chk("head0", 128'(out_slot(0)), 128'(sb[0]));
            if (n >= 2) chk("head1", 128'(out_slot(1)), 128'(sb[1]));
            if (flush) sb.delete();
            else begin
                if (!issue_stall) begin
                    if (v0) void'(sb.pop_front());
                    if (v1) void'(sb.pop_front());
                end
                if (n <= DEPTH - 2 && in_valid[0]) begin
                    sb.push_back(in_slot(0));
                    if (in_valid[1]) sb.push_back(in_slot(1));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // asynchronous reset mid-run with 5 entries held
        drive(2'b11, alu(32'h10, 5'd1), alu(32'h14, 5'd2), 1'b1, 1'b0);
        drive(2'b11, alu(32'h18, 5'd3), alu(32'h1c, 5'd4), 1'b1, 1'b0);
        drive(2'b01, alu(32'h20, 5'd5), '0, 1'b1, 1'b0);
        chk("pre_rst_count", 128'(count), 128'(5));
        rst_n = 0;
        #1;
        chk("async_count", 128'(count), 128'(0));
        chk("async_empty", 128'(empty), 128'(1));
        chk("async_out_valid", 128'(out_valid), 128'(0));
        chk("async_in_ready", 128'(in_ready), 128'(1));
        idle(1'b0);
        rst_n = 1;
        drive(2'b11, alu(32'h100, 5'd1), alu(32'h104, 5'd2), 1'b1, 1'b0);
        chk("first_pair_valid", 128'(out_valid), 128'(2'b11));
        chk("first_pair_pc", 128'(out_pc), 128'({32'h104, 32'h100}));
        do_flush();

        // RAW hazard, then the same shape through x0
        drive(2'b11, alu(32'h200, 5'd5), mk(32'h204, 5'd6, 5'd5, 5'd0, 1, 1, 0, 0, 0), 1'b1, 1'b0);
        chk("raw_block", 128'(out_valid), 128'(2'b01));
        idle(1'b0);
        chk("raw_pop1_count", 128'(count), 128'(1));
        chk("raw_pop1_head", 128'(out_pc[0]), 128'(32'h204));
        chk("raw_pop1_valid", 128'(out_valid), 128'(2'b01));
        idle(1'b0);
        pair_test("raw_x0", alu(32'h300, 5'd0), mk(32'h304, 5'd6, 5'd0, 5'd0, 1, 1, 0, 0, 0), 2'b11);

        // pipeline resource conflicts
        pair_test("two_loads", mk(32'h310, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 0),
                  mk(32'h314, 5'd3, 5'd4, 5'd0, 1, 1, 0, 1, 0), 2'b01);
        pair_test("load_branch", mk(32'h320, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 0),
                  mk(32'h324, 5'd0, 5'd3, 5'd4, 0, 1, 1, 0, 1), 2'b11);
        pair_test("branch_alu", mk(32'h330, 5'd0, 5'd3, 5'd4, 0, 1, 1, 0, 1), alu(32'h334, 5'd7), 2'b01);
        pair_test("alu_alu", alu(32'h340, 5'd8), alu(32'h344, 5'd9), 2'b11);
        pair_test("waw", alu(32'h350, 5'd8), alu(32'h354, 5'd8), 2'b01);

        // full and backpressure
        for (int i = 0; i < 4; i++)
            drive(2'b11, alu(32'h400 + 16 * i, 5'(2 * i + 1)), alu(32'h404 + 16 * i, 5'(2 * i + 2)), 1'b1, 1'b0);
        chk("full_count", 128'(count), 128'(8));
        chk("full_in_ready", 128'(in_ready), 128'(0));
        drive(2'b11, alu(32'h480, 5'd20), alu(32'h484, 5'd21), 1'b1, 1'b0);
        chk("full_drop_count", 128'(count), 128'(8));
        idle(1'b0);
        chk("drain_count", 128'(count), 128'(6));
        chk("drain_in_ready", 128'(in_ready), 128'(1));
        do_flush();

        // walk the pointers to 7, then straddle the wrap
        for (int i = 0; i < 3; i++)
            drive(2'b11, alu(32'h500 + 8 * i, 5'(2 * i + 1)), alu(32'h504 + 8 * i, 5'(2 * i + 2)), 1'b1, 1'b0);
        drive(2'b01, alu(32'h518, 5'd7), '0, 1'b1, 1'b0);
        repeat (4) idle(1'b0);
        chk("walk_empty", 128'(count), 128'(0));
        for (int i = 0; i < 3; i++)
            drive(2'b11, alu(32'h600 + 8 * i, 5'(2 * i + 1)), alu(32'h604 + 8 * i, 5'(2 * i + 2)), 1'b1, 1'b0);
        drive(2'b01, alu(32'h618, 5'd7), '0, 1'b1, 1'b0);
        chk("wrap_count", 128'(count), 128'(7));
        chk("wrap_valid", 128'(out_valid), 128'(2'b11));
        chk("wrap_pc", 128'(out_pc), 128'({32'h604, 32'h600}));
        idle(1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, alu(32'h700 + 8 * i, 5'((2 * i) % 30 + 1)), alu(32'h704 + 8 * i, 5'((2 * i) % 30 + 2)),
                  1'b0, 1'b0);
            chk("steady_count", 128'(count), 128'(5));
        end
        do_flush();

        // flush beats a same-cycle push
        for (int i = 0; i < 3; i++)
            drive(2'b11, alu(32'h800 + 8 * i, 5'(2 * i + 1)), alu(32'h804 + 8 * i, 5'(2 * i + 2)), 1'b1, 1'b0);
        chk("preflush_count", 128'(count), 128'(6));
        drive(2'b11, alu(32'h900, 5'd1), alu(32'h904, 5'd2), 1'b1, 1'b1);
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        drive(2'b01, alu(32'ha00, 5'd3), '0, 1'b1, 1'b0);
        chk("postflush_valid", 128'(out_valid), 128'(2'b01));
        chk("postflush_pc", 128'(out_pc[0]), 128'(32'ha00));
        do_flush();

        // random traffic, including the illegal 2'b10 request
        for (int i = 0; i < 400; i++)
            drive(2'($urandom_range(0, 3)), rnd(32'h1000 + 8 * i), rnd(32'h1004 + 8 * i),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
        repeat (6) idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
